oled_text_sequencer: RTL and testbench
======================================

// Module: oled_text_sequencer
// PURPOSE
//  Upstream feeder for OLED_interface. Buffers ASCII bytes in a FIFO, fetches each glyph from an external font ROM,
//  and issues one OLED_interface command per character cell. Tracks the cursor over the character grid.
//  After every reset it issues the power-on command before any character command.
// PARAMETERS
//  NUM_COL        4  OLED pixel columns; CHARS_PER_ROW = NUM_COL/ASCII_COL_SIZE
//  NUM_ROW        4  OLED pixel rows; CHAR_ROWS = NUM_ROW/ASCII_ROW_SIZE
//  ASCII_COL_SIZE 2  glyph width in pixels
//  ASCII_ROW_SIZE 2  glyph height in pixels; G = ASCII_COL_SIZE*ASCII_ROW_SIZE
//  FIFO_DEPTH     8  character FIFO entries; power of 2, >=2
// PORTS
//  i_CLK          in   1   system clock, all logic on posedge
//  i_RST          in   1   synchronous, active-high reset
//  i_CHAR         in   8   ASCII byte to display
//  i_CHAR_VALID   in   1   i_CHAR valid; push occurs when i_CHAR_VALID && o_CHAR_READY
//  o_CHAR_READY   out  1   FIFO not full
//  o_GLYPH_ADDR   out  8   font ROM address (= character code)
//  i_GLYPH_BITS   in   G   font ROM data, valid 1 cycle after o_GLYPH_ADDR; 1 = text colour
//  o_MODE         out  2   OLED_interface mode: 00 power-on, 01 clear, 10 pixel/glyph display
//  o_START        out  1   OLED_interface start request
//  o_PIXEL        out  G   glyph bits to OLED_interface i_PIXEL
//  i_OLED_READY   in   1   OLED_interface o_READY
//  o_BUSY         out  1   high in any state except IDLE
//  o_CURSOR_COL   out  clog2(CHARS_PER_ROW) (min 1)  next cell column
//  o_CURSOR_ROW   out  clog2(CHAR_ROWS) (min 1)      next cell row
//  o_FIFO_COUNT   out  clog2(FIFO_DEPTH)+1           entries held
// BEHAVIOUR
//  Reset values: o_START=0, o_MODE=00, o_PIXEL=0, o_GLYPH_ADDR=0, cursor=0/0, FIFO empty, o_CHAR_READY=1, o_BUSY=1, state=PWR_ON.
//  Reset mid-command: o_START drops on the next edge; the FIFO is flushed and the power-on sequence is rerun.
//  FIFO:
//   - o_CHAR_READY = (count != FIFO_DEPTH); a push at full is blocked even with a pop in the same cycle.
//   - Simultaneous push and pop when not full leaves count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Pushes are accepted in every state, including PWR_ON.
//  OLED handshake, identical for every command:
//   - Drive o_MODE and o_PIXEL, assert o_START (CMD).
//   - Hold o_START until i_OLED_READY is sampled low (ACK), then deassert.
//   - Wait for i_OLED_READY to be sampled high (DONE).
//   - o_MODE and o_PIXEL stay stable from CMD through DONE.
//  FSM:
//   - PWR_ON: MODE 00 handshake, then IDLE.
//   - IDLE: FIFO non-empty -> pop and drive o_GLYPH_ADDR, go to FETCH.
//   - FETCH: 1 wait cycle, then LATCH.
//   - LATCH: o_PIXEL <= i_GLYPH_BITS, go to CMD with MODE 10.
//   - After DONE: cursor advances, then IDLE.
//   - Pop-to-o_START latency: 3 cycles.
//  Cursor: col+1; at CHARS_PER_ROW-1 col=0 and row+1; at the last cell wraps to 0/0.
//  o_GLYPH_ADDR holds its last value outside FETCH.
// CONFIGURATION
//  OLED_TEXT_CTRL_EN defined: control bytes are interpreted and never sent to the ROM.
//   - 0x0A newline, cursor col != 0: PAD state issues MODE 10 commands with o_PIXEL=0 until col wraps to 0.
//   - 0x0A newline, cursor col == 0: no command is issued.
//   - 0x0C form feed: one MODE 01 handshake; cursor = 0/0.
//  OLED_TEXT_CTRL_EN undefined: every byte, including 0x0A and 0x0C, is treated as a glyph.
// TESTING
//  1 Reset release, i_OLED_READY high -> o_START=1 with o_MODE=00.
//    Model drops ready for 5 cycles -> single MODE 00 handshake, then o_BUSY=0.
//  2 Push 0x41, ROM returns 4'b1010 -> o_GLYPH_ADDR=0x41.
//    o_START 3 cycles after the pop with o_MODE=10, o_PIXEL=1010 -> cursor 0/0 -> 1/0.
//  3 Push 9 bytes, i_OLED_READY held high, FIFO_DEPTH=8 -> o_CHAR_READY=0 after the 8th (or 9th if one popped).
//    No byte lost or duplicated; output order equals push order.
//  4 Five glyphs on the 2x2 grid -> cursor sequence 0/0,1/0,0/1,1/1,0/0; the 5th is drawn at the wrapped cell.
//  5 CTRL_EN, cursor col=1, push 0x0A -> one MODE 10 command with o_PIXEL=0000, cursor 0/1.
//    Push 0x0C -> one MODE 01 command, cursor 0/0.
//  6 i_RST pulsed while waiting for ready low -> o_START=0 next cycle, o_FIFO_COUNT=0, MODE 00 reissued.

Source files
------------

// File: rtl/oled_text_sequencer_if.sv
// Character stream and OLED_interface command bus between the text sequencer and its neighbours.
// Signal names follow the sequencer's point of view (i_ = into the sequencer, o_ = out of it).
interface oled_text_sequencer_if #(
    parameter int G = 4
);
    logic [7:0]   i_CHAR;
    logic         i_CHAR_VALID;
    logic         o_CHAR_READY;
    logic [1:0]   o_MODE;
    logic         o_START;
    logic [G-1:0] o_PIXEL;
    logic         i_OLED_READY;

    modport master (
        input  i_CHAR, i_CHAR_VALID, i_OLED_READY,
        output o_CHAR_READY, o_MODE, o_START, o_PIXEL
    );

    modport slave (
        output i_CHAR, i_CHAR_VALID, i_OLED_READY,
        input  o_CHAR_READY, o_MODE, o_START, o_PIXEL
    );
endinterface

// File: rtl/oled_text_sequencer.sv
// Text front end for OLED_interface: character FIFO, font ROM fetch, per-cell command handshake, cursor.
// Optional macro OLED_TEXT_CTRL_EN enables newline (0x0A) and form-feed (0x0C) interpretation.
module oled_text_sequencer #(
    parameter int NUM_COL        = 4,
    parameter int NUM_ROW        = 4,
    parameter int ASCII_COL_SIZE = 2,
    parameter int ASCII_ROW_SIZE = 2,
    parameter int FIFO_DEPTH     = 8,
    localparam int G             = ASCII_COL_SIZE * ASCII_ROW_SIZE,
    localparam int CHARS_PER_ROW = NUM_COL / ASCII_COL_SIZE,
    localparam int CHAR_ROWS     = NUM_ROW / ASCII_ROW_SIZE,
    localparam int COL_W         = (CHARS_PER_ROW > 1) ? $clog2(CHARS_PER_ROW) : 1,
    localparam int ROW_W         = (CHAR_ROWS > 1) ? $clog2(CHAR_ROWS) : 1,
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    oled_text_sequencer_if.master bus,
    output logic [7:0]           o_GLYPH_ADDR,
    input  logic [G-1:0]         i_GLYPH_BITS,
    output logic                 o_BUSY,
    output logic [COL_W-1:0]     o_CURSOR_COL,
    output logic [ROW_W-1:0]     o_CURSOR_ROW,
    output logic [CNT_W-1:0]     o_FIFO_COUNT
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] MODE_PWR_ON = 2'b00;
    localparam logic [1:0] MODE_CLEAR  = 2'b01;
    localparam logic [1:0] MODE_PIXEL  = 2'b10;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHAR_ROWS - 1);

    typedef enum logic [2:0] {
        S_PWR_ON, S_IDLE, S_FETCH, S_LATCH, S_CMD, S_WAIT_DONE, S_PAD
    } state_t;

    typedef enum logic [1:0] {K_PWR, K_GLYPH, K_CLEAR, K_PAD} kind_t;

    state_t r_state, w_state_nxt;
    kind_t  r_kind;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_start;
    logic [1:0]       r_mode;
    logic [G-1:0]     r_pixel;
    logic [7:0]       r_glyph_addr;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic       w_full, w_push, w_pop;
    logic [7:0] w_head;
    logic       w_start_set, w_start_clr, w_load_addr, w_latch;
    logic       w_setup_pad, w_setup_clr, w_adv, w_cur_clr;

    // Row-major cursor step with wrap from the last cell back to the origin.
    function automatic logic [ROW_W+COL_W-1:0] next_cell(input logic [COL_W-1:0] col,
                                                          input logic [ROW_W-1:0] row);
        logic [COL_W-1:0] c;
        logic [ROW_W-1:0] r;
        c = col + 1'b1;
        r = row;
        if (col == LAST_COL) begin
            c = '0;
            r = (row == LAST_ROW) ? '0 : row + 1'b1;
        end
        return {r, c};
    endfunction

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push = bus.i_CHAR_VALID && !w_full;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge i_CLK) begin
        if (i_RST) r_state <= S_PWR_ON;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start_set = 1'b0;
        w_start_clr = 1'b0;
        w_load_addr = 1'b0;
        w_latch     = 1'b0;
        w_setup_pad = 1'b0;
        w_setup_clr = 1'b0;
        w_adv       = 1'b0;
        w_cur_clr   = 1'b0;
        unique case (r_state)
            S_PWR_ON, S_CMD: begin
                // START rises on the first cycle here and is held until READY is seen low.
                if (!r_start) begin
                    w_start_set = 1'b1;
                end else if (!bus.i_OLED_READY) begin
                    w_start_clr = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
`ifdef OLED_TEXT_CTRL_EN
                    if (w_head == 8'h0A) begin
                        if (r_col != '0) w_state_nxt = S_PAD;
                    end else if (w_head == 8'h0C) begin
                        w_setup_clr = 1'b1;
                        w_state_nxt = S_CMD;
                    end else begin
                        w_load_addr = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
`else
                    w_load_addr = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = S_CMD;
            end
            S_PAD: begin
                w_setup_pad = 1'b1;
                w_state_nxt = S_CMD;
            end
            S_WAIT_DONE: begin
                if (bus.i_OLED_READY) begin
                    w_state_nxt = S_IDLE;
                    unique case (r_kind)
                        K_PWR:   ;
                        K_GLYPH: w_adv = 1'b1;
                        K_CLEAR: w_cur_clr = 1'b1;
                        K_PAD: begin
                            w_adv = 1'b1;
                            if (r_col != LAST_COL) w_state_nxt = S_PAD;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = S_PWR_ON;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.i_CHAR;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_start      <= 1'b0;
            r_mode       <= MODE_PWR_ON;
            r_pixel      <= '0;
            r_glyph_addr <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_kind       <= K_PWR;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_start_set)      r_start <= 1'b1;
            else if (w_start_clr) r_start <= 1'b0;
            if (w_load_addr) r_glyph_addr <= w_head;
            if (w_latch) begin
                r_pixel <= i_GLYPH_BITS;
                r_mode  <= MODE_PIXEL;
                r_kind  <= K_GLYPH;
            end
            if (w_setup_pad) begin
                r_pixel <= '0;
                r_mode  <= MODE_PIXEL;
                r_kind  <= K_PAD;
            end
            if (w_setup_clr) begin
                r_pixel <= '0;
                r_mode  <= MODE_CLEAR;
                r_kind  <= K_CLEAR;
            end
            if (w_cur_clr) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_adv) begin
                {r_row, r_col} <= next_cell(r_col, r_row);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.o_CHAR_READY = !w_full;
    assign bus.o_MODE       = r_mode;
    assign bus.o_START      = r_start;
    assign bus.o_PIXEL      = r_pixel;
    assign o_GLYPH_ADDR     = r_glyph_addr;
    assign o_BUSY           = (r_state != S_IDLE);
    assign o_CURSOR_COL     = r_col;
    assign o_CURSOR_ROW     = r_row;
    assign o_FIFO_COUNT     = r_count;
endmodule

// File: tb/tb_oled_text_sequencer.sv
// Bench for oled_text_sequencer on a 2x2 character grid with 2x2-pixel glyphs and an 8-entry FIFO.
// An OLED_interface model acknowledges each START and compares it against a queue of expected commands.
module tb_oled_text_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] glyph_addr;
    logic [3:0] rom_bits = 4'h0;
    logic [7:0] addr_d = 8'h00;
    logic       busy;
    logic [0:0] cur_col, cur_row;
    logic [3:0] fifo_cnt;

    int errors = 0;
    int checks = 0;
    int n_cmds = 0;
    int mbusy  = 0;
    bit model_en = 1'b1;
    logic [1:0] cap_mode;
    logic [3:0] cap_pix;
    logic exp_col = 1'b0;
    logic exp_row = 1'b0;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] pixel;
        bit         chk_pix;
        logic [7:0] addr;
        bit         chk_addr;
        logic       col;
        logic       row;
    } cmd_t;
    cmd_t sb[$];

    oled_text_sequencer_if #(.G(4)) bus ();

    oled_text_sequencer dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .bus          (bus),
        .o_GLYPH_ADDR (glyph_addr),
        .i_GLYPH_BITS (rom_bits),
        .o_BUSY       (busy),
        .o_CURSOR_COL (cur_col),
        .o_CURSOR_ROW (cur_row),
        .o_FIFO_COUNT (fifo_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_fn(input logic [7:0] a);
        return a[3:0] ^ 4'hB;
    endfunction

    // Font ROM with exactly one cycle of address-to-data latency.
    always @(negedge clk) begin
        rom_bits = rom_fn(addr_d);
        addr_d   = glyph_addr;
    end

    // OLED_interface model: ready drops for 5 cycles per accepted START.
    always @(negedge clk) begin
        cmd_t e;
        if (rst) begin
            bus.i_OLED_READY = 1'b1;
            mbusy = 0;
        end else if (mbusy > 0) begin
            checks++;
            if (bus.o_MODE !== cap_mode || bus.o_PIXEL !== cap_pix) begin
                errors++;
                $display("FAIL cmd_stable: mode=%b pixel=%b required mode=%b pixel=%b",
                         bus.o_MODE, bus.o_PIXEL, cap_mode, cap_pix);
            end
            mbusy--;
            if (mbusy == 0) bus.i_OLED_READY = 1'b1;
        end else if (model_en && bus.o_START === 1'b1 && bus.i_OLED_READY) begin
            n_cmds++;
            cap_mode = bus.o_MODE;
            cap_pix  = bus.o_PIXEL;
            bus.i_OLED_READY = 1'b0;
            mbusy = 5;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: mode=%b pixel=%b required no command", bus.o_MODE, bus.o_PIXEL);
            end else begin
                e = sb.pop_front();
                if (bus.o_MODE !== e.mode) begin
                    errors++;
                    $display("FAIL cmd_mode: got %b required %b", bus.o_MODE, e.mode);
                end
                checks++;
                if (e.chk_pix && bus.o_PIXEL !== e.pixel) begin
                    errors++;
                    $display("FAIL cmd_pixel: got %b required %b", bus.o_PIXEL, e.pixel);
                end
                checks++;
                if (e.chk_addr && glyph_addr !== e.addr) begin
                    errors++;
                    $display("FAIL cmd_glyph_addr: got %h required %h", glyph_addr, e.addr);
                end
                checks++;
                if (cur_col !== e.col || cur_row !== e.row) begin
                    errors++;
                    $display("FAIL cmd_cursor: got %0d/%0d required %0d/%0d", cur_col, cur_row, e.col, e.row);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic exp_adv();
        if (exp_col) begin
            exp_col = 1'b0;
            exp_row = ~exp_row;
        end else begin
            exp_col = 1'b1;
        end
    endtask

    task automatic sb_cmd(input logic [1:0] m, input logic [3:0] p, input bit cp,
                          input logic [7:0] a, input bit ca);
        cmd_t e;
        e.mode = m; e.pixel = p; e.chk_pix = cp; e.addr = a; e.chk_addr = ca;
        e.col = exp_col; e.row = exp_row;
        sb.push_back(e);
    endtask

    task automatic sb_pwr();
        sb_cmd(2'b00, 4'h0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic sb_char(input logic [7:0] c);
`ifdef OLED_TEXT_CTRL_EN
        if (c == 8'h0A) begin
            while (exp_col != 1'b0) begin
                sb_cmd(2'b10, 4'h0, 1'b1, 8'h00, 1'b0);
                exp_adv();
            end
            return;
        end
        if (c == 8'h0C) begin
            sb_cmd(2'b01, 4'h0, 1'b0, 8'h00, 1'b0);
            exp_col = 1'b0;
            exp_row = 1'b0;
            return;
        end
`endif
        sb_cmd(2'b10, rom_fn(c), 1'b1, c, 1'b1);
        exp_adv();
    endtask

    task automatic push_byte(input logic [7:0] c, input bit track);
        for (int i = 0; i < 200 && !bus.o_CHAR_READY; i++) @(negedge clk);
        bus.i_CHAR = c;
        bus.i_CHAR_VALID = 1'b1;
        if (track) sb_char(c);
        @(negedge clk);
        bus.i_CHAR_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !busy && fifo_cnt == 0 && mbusy == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_START !== 1'b0 || bus.o_MODE !== 2'b00 || bus.o_PIXEL !== 4'h0) begin
            errors++;
            $display("FAIL reset_cmd: start=%b mode=%b pixel=%b required 0/00/0000", bus.o_START, bus.o_MODE, bus.o_PIXEL);
        end
        checks++;
        if (glyph_addr !== 8'h00 || cur_col !== 1'b0 || cur_row !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr_cursor: addr=%h cursor=%0d/%0d required 00 0/0", glyph_addr, cur_col, cur_row);
        end
        checks++;
        if (fifo_cnt !== 4'd0 || bus.o_CHAR_READY !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo_busy: count=%0d ready=%b busy=%b required 0 1 1", fifo_cnt, bus.o_CHAR_READY, busy);
        end
        sb_pwr();
        n0 = n_cmds;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_START !== 1'b1 || bus.o_MODE !== 2'b00) begin
            errors++;
            $display("FAIL pwr_on_start: start=%b mode=%b required 1 00", bus.o_START, bus.o_MODE);
        end
        drain();
        checks++;
        if (n_cmds - n0 !== 1 || busy !== 1'b0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL pwr_on_done: cmds=%0d busy=%b pending=%0d required 1 0 0", n_cmds - n0, busy, sb.size());
        end
    endtask

    task automatic test_single_char();
        int cyc;
        push_byte(8'h41, 1'b1);
        for (int i = 0; i < 20 && glyph_addr !== 8'h41; i++) @(negedge clk);
        checks++;
        if (glyph_addr !== 8'h41 || fifo_cnt !== 4'd0) begin
            errors++;
            $display("FAIL glyph_addr: addr=%h count=%0d required 41 0", glyph_addr, fifo_cnt);
        end
        cyc = 0;
        while (bus.o_START !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL pop_to_start: got %0d cycles required 3", cyc);
        end
        checks++;
        if (bus.o_MODE !== 2'b10 || bus.o_PIXEL !== 4'b1010) begin
            errors++;
            $display("FAIL glyph_cmd: mode=%b pixel=%b required 10 1010", bus.o_MODE, bus.o_PIXEL);
        end
        drain();
        checks++;
        if (cur_col !== 1'b1 || cur_row !== 1'b0) begin
            errors++;
            $display("FAIL cursor_after_A: got %0d/%0d required 1/0", cur_col, cur_row);
        end
    endtask

    task automatic test_fifo_full();
        int accepted = 0;
        model_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_CHAR = 8'h50 + 8'(i);
            bus.i_CHAR_VALID = 1'b1;
            if (bus.o_CHAR_READY) begin
                accepted++;
                sb_char(8'h50 + 8'(i));
            end
            @(negedge clk);
        end
        bus.i_CHAR_VALID = 1'b0;
        checks++;
        if (accepted !== 9 || fifo_cnt !== 4'd8 || bus.o_CHAR_READY !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: accepted=%0d count=%0d ready=%b required 9 8 0", accepted, fifo_cnt, bus.o_CHAR_READY);
        end
        model_en = 1'b1;
        drain();
        checks++;
        if (sb.size() !== 0 || fifo_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drain: pending=%0d count=%0d busy=%b required 0 0 0", sb.size(), fifo_cnt, busy);
        end
    endtask

    task automatic test_cursor_wrap();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_col = 1'b0;
        exp_row = 1'b0;
        sb_pwr();
        rst = 1'b0;
        drain();
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i), 1'b1);
        drain();
        checks++;
        if (sb.size() !== 0 || cur_col !== 1'b1 || cur_row !== 1'b0) begin
            errors++;
            $display("FAIL cursor_wrap: pending=%0d cursor=%0d/%0d required 0 1/0", sb.size(), cur_col, cur_row);
        end
    endtask

    task automatic test_ctrl();
        int n0;
`ifdef OLED_TEXT_CTRL_EN
        int d_nl = 1, d_ff = 1, d_nl0 = 0;
`else
        int d_nl = 1, d_ff = 1, d_nl0 = 1;
`endif
        n0 = n_cmds;
        push_byte(8'h0A, 1'b1);
        drain();
        checks++;
        if (n_cmds - n0 !== d_nl || cur_col !== exp_col || cur_row !== exp_row) begin
            errors++;
            $display("FAIL newline: cmds=%0d cursor=%0d/%0d required %0d %0d/%0d", n_cmds - n0, cur_col, cur_row, d_nl, exp_col, exp_row);
        end
        n0 = n_cmds;
        push_byte(8'h0C, 1'b1);
        drain();
        checks++;
        if (n_cmds - n0 !== d_ff || cur_col !== exp_col || cur_row !== exp_row) begin
            errors++;
            $display("FAIL formfeed: cmds=%0d cursor=%0d/%0d required %0d %0d/%0d", n_cmds - n0, cur_col, cur_row, d_ff, exp_col, exp_row);
        end
        n0 = n_cmds;
        push_byte(8'h0A, 1'b1);
        repeat (10) @(negedge clk);
        drain();
        checks++;
        if (n_cmds - n0 !== d_nl0 || cur_col !== exp_col || cur_row !== exp_row || sb.size() !== 0) begin
            errors++;
            $display("FAIL newline_col0: cmds=%0d cursor=%0d/%0d required %0d %0d/%0d", n_cmds - n0, cur_col, cur_row, d_nl0, exp_col, exp_row);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        model_en = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i), 1'b0);
        for (int i = 0; i < 50 && bus.o_START !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_START !== 1'b1 || fifo_cnt !== 4'd2) begin
            errors++;
            $display("FAIL hold_start: start=%b count=%0d required 1 2", bus.o_START, fifo_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_START !== 1'b0 || fifo_cnt !== 4'd0 || bus.o_MODE !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: start=%b count=%0d mode=%b busy=%b required 0 0 00 1", bus.o_START, fifo_cnt, bus.o_MODE, busy);
        end
        sb.delete();
        exp_col = 1'b0;
        exp_row = 1'b0;
        sb_pwr();
        model_en = 1'b1;
        n0 = n_cmds;
        @(negedge clk);
        rst = 1'b0;
        drain();
        checks++;
        if (n_cmds - n0 !== 1 || busy !== 1'b0 || sb.size() !== 0 || fifo_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_rerun: cmds=%0d busy=%b pending=%0d count=%0d required 1 0 0 0", n_cmds - n0, busy, sb.size(), fifo_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_CHAR = 8'h00;
        bus.i_CHAR_VALID = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_char();
        test_fifo_full();
        test_cursor_wrap();
        test_ctrl();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
